// File: rtl/countdown_timer_fsm.sv
// Loadable N-bit down-counter with IDLE/RUN/PAUSE/DONE control, one-cycle done
// pulse, pause, abort and optional automatic reload of the latched start value.
module countdown_timer_fsm #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  input  logic         pause,
  input  logic         stop,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d  = load_val;
          reload_d = load_val;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          count_d = '0;
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (count_q > N'(1)) begin
          count_d = count_q - N'(1);
        end else begin
          // Covers both the final 1->0 step and a zero start value: never wraps.
          count_d = '0;
          state_d = DONE;
        end
      end

      PAUSE: begin
        if (stop) begin
          count_d = '0;
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (start) begin
          count_d  = load_val;
          reload_d = load_val;
          state_d  = RUN;
        end else if (stop) begin
          count_d = '0;
          state_d = IDLE;
        end else if (auto_reload && (reload_q != '0)) begin
          count_d = reload_q;
          state_d = RUN;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase

    // Flags track the next state so they register alongside it.
    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_countdown_timer_fsm.sv
// Directed self-checking bench for countdown_timer_fsm: every output is checked
// one time unit after each rising edge against hand-derived values.
module tb_countdown_timer_fsm;

  localparam int N = 5;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic         pause = 1'b0;
  logic         stop = 1'b0;
  logic [N-1:0] count;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;

  countdown_timer_fsm #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .pause      (pause),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // busy/done expectations follow from the state being expected.
  task automatic chk(input string tag, input int exp_count, input logic [1:0] exp_state);
    logic [N-1:0] ec;
    logic         eb;
    logic         ed;
    ec = N'(exp_count);
    eb = (exp_state == S_RUN) || (exp_state == S_PAUSE);
    ed = (exp_state == S_DONE);
    checks++;
    assert ({count, state, busy, done} === {ec, exp_state, eb, ed})
    else begin
      errors++;
      $error("FAIL %s: got count=%0d state=%b busy=%b done=%b, expected count=%0d state=%b busy=%b done=%b",
             tag, count, state, busy, done, ec, exp_state, eb, ed);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across edges
    tick();
    tick();
    chk("reset_hold", 0, S_IDLE);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 0, S_IDLE);

    // L=5 basic countdown
    start = 1'b1; load_val = 5'd5;
    tick();
    start = 1'b0;
    chk("l5_load", 5, S_RUN);
    for (int v = 4; v >= 1; v--) begin
      tick();
      chk("l5_dec", v, S_RUN);
    end
    tick();
    chk("l5_done", 0, S_DONE);
    tick();
    chk("l5_idle", 0, S_IDLE);

    // L=0: one RUN cycle then DONE
    start = 1'b1; load_val = 5'd0;
    tick();
    start = 1'b0;
    chk("l0_run", 0, S_RUN);
    tick();
    chk("l0_done", 0, S_DONE);
    tick();
    chk("l0_idle", 0, S_IDLE);

    // L=3 with auto reload: two full periods then release
    auto_reload = 1'b1;
    start = 1'b1; load_val = 5'd3;
    tick();
    start = 1'b0;
    chk("ar_load", 3, S_RUN);
    tick(); chk("ar_p1_2", 2, S_RUN);
    tick(); chk("ar_p1_1", 1, S_RUN);
    tick(); chk("ar_p1_done", 0, S_DONE);
    tick(); chk("ar_p2_3", 3, S_RUN);
    tick(); chk("ar_p2_2", 2, S_RUN);
    tick(); chk("ar_p2_1", 1, S_RUN);
    auto_reload = 1'b0;
    tick(); chk("ar_p2_done", 0, S_DONE);
    tick(); chk("ar_idle", 0, S_IDLE);

    // L=6 with pause sampled on three edges at count 4
    start = 1'b1; load_val = 5'd6;
    tick();
    start = 1'b0;
    chk("pa_load", 6, S_RUN);
    tick(); chk("pa_5", 5, S_RUN);
    tick(); chk("pa_4", 4, S_RUN);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pa_hold", 4, S_PAUSE);
    end
    pause = 1'b0;
    tick(); chk("pa_resume", 4, S_RUN);
    for (int v = 3; v >= 1; v--) begin
      tick();
      chk("pa_dec", v, S_RUN);
    end
    tick(); chk("pa_done", 0, S_DONE);
    tick(); chk("pa_idle", 0, S_IDLE);

    // Stop at count 2, then stop together with pause
    for (int rep = 0; rep < 2; rep++) begin
      start = 1'b1; load_val = 5'd5;
      tick();
      start = 1'b0;
      chk("st_load", 5, S_RUN);
      tick(); chk("st_4", 4, S_RUN);
      tick(); chk("st_3", 3, S_RUN);
      tick(); chk("st_2", 2, S_RUN);
      stop = 1'b1;
      pause = (rep == 1);
      tick(); chk("st_abort", 0, S_IDLE);
      stop = 1'b0;
      pause = 1'b0;
      tick(); chk("st_no_done", 0, S_IDLE);
    end

    // start mid-RUN is ignored
    start = 1'b1; load_val = 5'd4;
    tick();
    start = 1'b0;
    chk("sm_load", 4, S_RUN);
    tick(); chk("sm_3", 3, S_RUN);
    start = 1'b1; load_val = 5'd9;
    tick(); chk("sm_ignored", 2, S_RUN);
    start = 1'b0;
    tick(); chk("sm_1", 1, S_RUN);
    tick(); chk("sm_done", 0, S_DONE);
    tick(); chk("sm_idle", 0, S_IDLE);

    // start in DONE beats auto_reload
    auto_reload = 1'b1;
    start = 1'b1; load_val = 5'd1;
    tick();
    start = 1'b0;
    chk("sd_load", 1, S_RUN);
    tick(); chk("sd_done1", 0, S_DONE);
    start = 1'b1; load_val = 5'd2;
    tick(); chk("sd_reload2", 2, S_RUN);
    start = 1'b0;
    auto_reload = 1'b0;
    tick(); chk("sd_1", 1, S_RUN);
    tick(); chk("sd_done2", 0, S_DONE);
    tick(); chk("sd_idle", 0, S_IDLE);

    // Asynchronous reset mid-count
    start = 1'b1; load_val = 5'd10;
    tick();
    start = 1'b0;
    tick();
    tick(); chk("ar_mid", 8, S_RUN);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0, S_IDLE);
    rst_n = 1'b1;
    tick(); chk("post_reset_1", 0, S_IDLE);
    tick(); chk("post_reset_2", 0, S_IDLE);

    // Maximum load value: 31 steps, no wrap
    start = 1'b1; load_val = 5'd31;
    tick();
    start = 1'b0;
    chk("max_load", 31, S_RUN);
    for (int v = 30; v >= 1; v--) begin
      tick();
      chk("max_dec", v, S_RUN);
    end
    tick(); chk("max_done", 0, S_DONE);
    tick(); chk("max_idle", 0, S_IDLE);
    tick(); chk("max_no_wrap", 0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
